uart_rx_decoder: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx_decoder.sv | 111 +++++++++++
 tb/tb_uart_rx_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to 1 so an idle serial line is not seen as a start
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - 8N1 UART receiver, mid-bit sampling, one-cycle valid strobe per good frame
module uart_rx_decoder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_rx_state_e   state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;

    sync_2ff u_sync (
        .clk (i_Clock),
        .rst (i_Reset),
        .d   (i_Rx_Serial),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = START;
            end
            // Re-check half a bit in so a short low glitch does not start a frame.
            START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            // Leaving mid stop bit keeps back-to-back frames aligned.
            STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
        end
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb/tb_uart_rx_decoder.sv - directed bench for uart_rx_decoder at 868 and 16 clocks per bit
module tb_uart_rx_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;

    int total = 0;
    int bad   = 0;
    int dbl_a = 0;
    int dbl_b = 0;
    logic dv_a_prev = 1'b0;
    logic dv_b_prev = 1'b0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_decoder #(.CLKS_PER_BIT(868)) dut_a (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx_a),
        .o_Rx_DV     (dv_a),
        .o_Rx_Byte   (byte_a)
    );

    uart_rx_decoder #(.CLKS_PER_BIT(16)) dut_b (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx_b),
        .o_Rx_DV     (dv_b),
        .o_Rx_Byte   (byte_b)
    );

    always @(negedge clk) begin
        if (dv_a) q_a.push_back(byte_a);
        if (dv_b) q_b.push_back(byte_b);
        if (dv_a && dv_a_prev) dbl_a <= dbl_a + 1;
        if (dv_b && dv_b_prev) dbl_b <= dbl_b + 1;
        dv_a_prev <= dv_a;
        dv_b_prev <= dv_b;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int sel, input logic v, input int n);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        wait_cycles(n);
    endtask

    task automatic send(input int sel, input logic [7:0] b, input logic stop);
        int cpb;
        cpb = (sel == 0) ? 868 : 16;
        drive_bit(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i], cpb);
        drive_bit(sel, stop, cpb);
    endtask

    task automatic pop_check(input int sel, input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = 32'hFFFF_FFFF;
        if (sel == 0) begin
            if (q_a.size() > 0) got = {24'h0, q_a.pop_front()};
        end else begin
            if (q_b.size() > 0) got = {24'h0, q_b.pop_front()};
        end
        check_eq(tag, got, {24'h0, exp});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v99;
        v99 = 8'h99;

        wait_cycles(3);
        check_eq("rst_dv_a", {31'h0, dv_a}, 32'h0);
        check_eq("rst_byte_a", {24'h0, byte_a}, 32'h0);
        check_eq("rst_dv_b", {31'h0, dv_b}, 32'h0);
        check_eq("rst_byte_b", {24'h0, byte_b}, 32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // single byte at full baud divisor
        send(0, 8'h41, 1'b1);
        wait_cycles(20);
        check_eq("t1_count", q_a.size(), 32'd1);
        pop_check(0, "t1_byte_q", 8'h41);
        check_eq("t1_byte_out", {24'h0, byte_a}, 32'h41);

        // back-to-back frames
        send(1, 8'h00, 1'b1);
        send(1, 8'hFF, 1'b1);
        send(1, 8'hA5, 1'b1);
        send(1, 8'h5A, 1'b1);
        wait_cycles(20);
        check_eq("t2_count", q_b.size(), 32'd4);
        pop_check(1, "t2_b0", 8'h00);
        pop_check(1, "t2_b1", 8'hFF);
        pop_check(1, "t2_b2", 8'hA5);
        pop_check(1, "t2_b3", 8'h5A);

        // short glitch on idle line
        drive_bit(1, 1'b0, 4);
        drive_bit(1, 1'b1, 48);
        check_eq("t3_count", q_b.size(), 32'd0);
        check_eq("t3_byte", {24'h0, byte_b}, 32'h5A);

        // framing error followed by a break, then a good frame
        send(1, 8'h3C, 1'b0);
        drive_bit(1, 1'b0, 32);
        drive_bit(1, 1'b1, 32);
        check_eq("t4_err_count", q_b.size(), 32'd0);
        check_eq("t4_err_byte", {24'h0, byte_b}, 32'h5A);
        send(1, 8'h7E, 1'b1);
        wait_cycles(20);
        check_eq("t4_count", q_b.size(), 32'd1);
        pop_check(1, "t4_byte", 8'h7E);

        // reset in the middle of data bit 4
        drive_bit(1, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(1, v99[i], 16);
        drive_bit(1, v99[4], 8);
        rst = 1'b1;
        wait_cycles(2);
        check_eq("t5_rst_dv", {31'h0, dv_b}, 32'h0);
        check_eq("t5_rst_byte", {24'h0, byte_b}, 32'h0);
        rst = 1'b0;
        drive_bit(1, 1'b1, 48);
        check_eq("t5_abort_count", q_b.size(), 32'd0);
        check_eq("t5_abort_byte", {24'h0, byte_b}, 32'h0);
        send(1, 8'h12, 1'b1);
        wait_cycles(20);
        check_eq("t5_count", q_b.size(), 32'd1);
        pop_check(1, "t5_byte", 8'h12);

        // console string at full baud divisor
        send(0, 8'h48, 1'b1);
        send(0, 8'h69, 1'b1);
        send(0, 8'h0A, 1'b1);
        wait_cycles(20);
        check_eq("t6_count", q_a.size(), 32'd3);
        pop_check(0, "t6_H", 8'h48);
        pop_check(0, "t6_i", 8'h69);
        pop_check(0, "t6_nl", 8'h0A);
        check_eq("t6_byte_out", {24'h0, byte_a}, 32'h0A);
        check_eq("dv_double_a", dbl_a, 32'd0);
        check_eq("dv_double_b", dbl_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
